// File: rtl/store_monitor_if.sv
// Store bus from the core's data-memory write port into the self-check monitor.
interface store_monitor_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  modport master (output memwrite, output dataadr, output writedata);
  modport slave  (input  memwrite, input  dataadr, input  writedata);
endinterface

// File: rtl/store_monitor.sv
// Hardware pass/fail/timeout verdict for the MIPS core, plus a circular log
// of the most recent stores for post-mortem readback.
module store_monitor #(
  parameter logic [31:0] PASS_ADDR    = 32'd84,
  parameter logic [31:0] PASS_DATA    = 32'hFFFF7F02,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int unsigned LOG_DEPTH    = 8,
  localparam int unsigned IW          = $clog2(LOG_DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  store_monitor_if.slave      s_st,
  input  logic [IW-1:0]       i_log_rd_idx,
  output logic [31:0]         o_log_rd_addr,
  output logic [31:0]         o_log_rd_data,
  output logic [1:0]          o_state,
  output logic                o_done,
  output logic                o_pass,
  output logic                o_fail,
  output logic [15:0]         o_store_count,
  output logic [15:0]         o_cycle_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } st_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_ent_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  st_e          r_state, w_state_nxt;
  log_ent_t     r_log [LOG_DEPTH];
  logic [IW-1:0] r_wr_ptr;
  logic [15:0]  r_store_count;
  logic [15:0]  r_cycle_count;

  logic          w_run, w_accept, w_sig, w_scratch;
  logic [IW-1:0] w_rd_ptr;

  assign w_run     = (r_state == ST_RUN);
  assign w_accept  = w_run && s_st.memwrite;
  assign w_sig     = (s_st.dataadr == PASS_ADDR) && (s_st.writedata == PASS_DATA);
  assign w_scratch = (s_st.dataadr == SCRATCH_ADDR);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  // Store verdicts outrank the timeout on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    if (w_run) begin
      if (w_accept && w_sig)             w_state_nxt = ST_PASS;
      else if (w_accept && !w_scratch)   w_state_nxt = ST_FAIL;
      else if (r_cycle_count == TO_LAST) w_state_nxt = ST_TIMEOUT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr      <= '0;
      r_store_count <= '0;
      r_cycle_count <= '0;
      for (int i = 0; i < int'(LOG_DEPTH); i++) r_log[i] <= '0;
    end else if (w_run) begin
      r_cycle_count <= r_cycle_count + 16'd1;
      if (w_accept) begin
        r_log[r_wr_ptr] <= '{addr: s_st.dataadr, data: s_st.writedata};
        r_wr_ptr        <= r_wr_ptr + IW'(1);
        if (r_store_count != 16'hFFFF) r_store_count <= r_store_count + 16'd1;
      end
    end
  end

  // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
  assign w_rd_ptr      = r_wr_ptr - IW'(1) - i_log_rd_idx;
  assign o_log_rd_addr = r_log[w_rd_ptr].addr;
  assign o_log_rd_data = r_log[w_rd_ptr].data;

  assign o_state       = r_state;
  assign o_done        = (r_state != ST_RUN);
  assign o_pass        = (r_state == ST_PASS);
  assign o_fail        = (r_state == ST_FAIL) || (r_state == ST_TIMEOUT);
  assign o_store_count = r_store_count;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: reset, pass, bad data, bad address,
// timeout, timeout-vs-signature tie, log wrap and mid-run reset.
module tb_store_monitor;
  localparam logic [31:0] SIG = 32'hFFFF7F02;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  log_rd_idx = '0;
  logic [31:0] log_rd_addr, log_rd_data;
  logic [1:0]  state;
  logic        done, pass, fail;
  logic [15:0] store_count, cycle_count;
  int          checks = 0;
  int          errors = 0;

  store_monitor_if bus();

  store_monitor #(.TIMEOUT(20), .LOG_DEPTH(8)) dut (
    .i_clk(clk), .i_reset(reset), .s_st(bus.slave),
    .i_log_rd_idx(log_rd_idx), .o_log_rd_addr(log_rd_addr), .o_log_rd_data(log_rd_data),
    .o_state(state), .o_done(done), .o_pass(pass), .o_fail(fail),
    .o_store_count(store_count), .o_cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite = 1'b1; bus.dataadr = a; bus.writedata = d;
    tick();
    bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;
  endtask

  task automatic chk_log(input string tag, input int k, input logic [31:0] ea, input logic [31:0] ed);
    log_rd_idx = 3'(k);
    #1;
    chk({tag, "_addr"}, log_rd_addr, ea);
    chk({tag, "_data"}, log_rd_data, ed);
  endtask

  task automatic chk_flags(input string tag, input logic [1:0] st, input logic [15:0] sc);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_done"},  32'(done),  32'(st != 2'b00));
    chk({tag, "_pass"},  32'(pass),  32'(st == 2'b01));
    chk({tag, "_fail"},  32'(fail),  32'(st[1]));
    chk({tag, "_scnt"},  32'(store_count), 32'(sc));
  endtask

  initial begin
    bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;

    // Reset state
    do_reset(2);
    chk_flags("rst", 2'b00, 16'd0);
    chk("rst_ccnt", 32'(cycle_count), 32'd0);
    for (int k = 0; k < 8; k++) chk_log("rst_log", k, 32'd0, 32'd0);

    // Pass sequence
    store(32'd80, 32'd7);
    chk_flags("scratch", 2'b00, 16'd1);
    store(32'd84, SIG);
    chk_flags("pass", 2'b01, 16'd2);
    chk_log("pass_log0", 0, 32'd84, SIG);
    chk_log("pass_log1", 1, 32'd80, 32'd7);
    store(32'd80, 32'd1);
    chk_flags("pass_frozen", 2'b01, 16'd2);
    chk_log("pass_nolog", 0, 32'd84, SIG);

    // Wrong signature data, then a late correct signature is ignored
    do_reset(1);
    store(32'd84, 32'h12345678);
    chk_flags("baddata", 2'b10, 16'd1);
    store(32'd84, SIG);
    chk_flags("baddata_sticky", 2'b10, 16'd1);

    // Bad address
    do_reset(1);
    store(32'd88, 32'd0);
    chk_flags("badaddr", 2'b10, 16'd1);
    chk_log("badaddr_log", 0, 32'd88, 32'd0);

    // Timeout with no stores
    do_reset(2);
    repeat (19) tick();
    chk_flags("pre_to", 2'b00, 16'd0);
    chk("pre_to_ccnt", 32'(cycle_count), 32'd19);
    tick();
    chk_flags("to", 2'b11, 16'd0);
    chk("to_ccnt", 32'(cycle_count), 32'd20);
    repeat (3) tick();
    chk("to_frozen_ccnt", 32'(cycle_count), 32'd20);
    chk("to_frozen_state", 32'(state), 32'd3);

    // Signature on the timeout edge wins
    do_reset(2);
    repeat (19) tick();
    store(32'd84, SIG);
    chk_flags("to_tie", 2'b01, 16'd1);
    chk("to_tie_ccnt", 32'(cycle_count), 32'd20);

    // Log wrap
    do_reset(2);
    for (int i = 1; i <= 10; i++) store(32'd80, 32'(i));
    chk_flags("wrap", 2'b00, 16'd10);
    chk_log("wrap_idx0", 0, 32'd80, 32'd10);
    chk_log("wrap_idx7", 7, 32'd80, 32'd3);
    chk_log("wrap_idx2", 2, 32'd80, 32'd8);

    // Mid-run reset overrides a simultaneous signature store
    bus.memwrite = 1'b1; bus.dataadr = 32'd84; bus.writedata = SIG;
    do_reset(1);
    bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;
    chk_flags("midrst", 2'b00, 16'd0);
    chk("midrst_ccnt", 32'(cycle_count), 32'd0);
    for (int k = 0; k < 8; k++) chk_log("midrst_log", k, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
